// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared MIPS opcode/funct codes and helpers for the ID stage
//
// Purpose: opcode and funct encodings, architectural register indices and the
//          immediate sign-extension helper used by decode_stage and instr_decoder.
// Ports:   none (package).

package decode_stage_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// rtl/decode_stage_instr_decoder.sv - combinational opcode/funct decode for the ID stage
//
// Purpose: maps opcode/funct to destination register, write/load flags and
//          which source registers the instruction actually reads.
// Ports:
//   opcode, funct   in   instr[31:26], instr[5:0]
//   rt, rd          in   instr[20:16], instr[15:11]
//   dest            out  destination register, 0 when nothing is written
//   regwrite        out  instruction writes a non-zero GPR
//   memread         out  instruction is lw
//   uses_rs/uses_rt out  rs / rt operand is consumed

module instr_decoder
    import decode_stage_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] dest,
    output logic              regwrite,
    output logic              memread,
    output logic              uses_rs,
    output logic              uses_rt
);

    logic [REG_AW-1:0] raw_dest;
    logic              raw_we;

    always_comb begin
        raw_dest = '0;
        raw_we   = 1'b0;
        memread  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                raw_dest = rd;
                raw_we   = (funct != FN_JR);
            end
            OP_LW: begin
                raw_dest = rt;
                raw_we   = 1'b1;
                memread  = 1'b1;
            end
            OP_JAL: begin
                raw_dest = REG_AW'(REG_RA);
                raw_we   = 1'b1;
            end
            default: begin
                // 0x08..0x0F: immediate ALU group, result goes to rt
                if (opcode[5:3] == 3'b001) begin
                    raw_dest = rt;
                    raw_we   = 1'b1;
                end
            end
        endcase
    end

    // A write to $0 is discarded here so downstream never sees it flagged
    assign regwrite = raw_we && (raw_dest != REG_AW'(REG_ZERO));
    assign dest     = regwrite ? raw_dest : '0;

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)   || (opcode == OP_BNE);
    assign uses_rs = !((opcode == OP_J) || (opcode == OP_JAL));

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - MIPS ID stage: regfile read, decode, load-use hazard, ID/EX register
//
// Purpose: drives regfile read indices from the IF/ID instruction, decodes it,
//          stalls on load-use, and latches operands/control into ID/EX.
// Config:  WB_BYPASS_EN - when defined, a same-cycle WB write to rs/rt is
//          forwarded into the latched operand instead of the regfile data.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   if_valid, if_instr, if_pc     IF/ID contents
//   ex_ready, flush               EX accept / redirect kill
//   rreg1, rreg2, rdata1, rdata2  regfile read interface
//   wb_regwrite, wb_wreg, wb_wdata  WB write port (bypass source)
//   id_stall                      combinational hold for PC and IF/ID
//   ex_*                          ID/EX register outputs

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [31:0]       if_pc,
    input  logic              ex_ready,
    input  logic              flush,
    output logic [REG_AW-1:0] rreg1,
    output logic [REG_AW-1:0] rreg2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [31:0]       ex_imm,
    output logic [REG_AW-1:0] ex_dest,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic              ex_memread,
    output logic              ex_regwrite
);

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rd_idx;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_regwrite;
    logic              dec_memread;
    logic              dec_uses_rs;
    logic              dec_uses_rt;
    logic              hz;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    assign opcode = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign rreg1  = if_instr[21 +: REG_AW];
    assign rreg2  = if_instr[16 +: REG_AW];
    assign rd_idx = if_instr[11 +: REG_AW];

    instr_decoder #(.REG_AW(REG_AW)) u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .rt       (rreg2),
        .rd       (rd_idx),
        .dest     (dec_dest),
        .regwrite (dec_regwrite),
        .memread  (dec_memread),
        .uses_rs  (dec_uses_rs),
        .uses_rt  (dec_uses_rt)
    );

    // Load in EX whose result the instruction in ID needs: data only exists after MEM
    assign hz = ex_valid && ex_memread && (ex_dest != '0) && if_valid &&
                ((dec_uses_rs && (ex_dest == rreg1)) ||
                 (dec_uses_rt && (ex_dest == rreg2)));

    assign id_stall = (hz || !ex_ready) && !flush;

`ifdef WB_BYPASS_EN
    assign rs_val = (wb_regwrite && (wb_wreg != '0) && (wb_wreg == rreg1)) ? wb_wdata : rdata1;
    assign rt_val = (wb_regwrite && (wb_wreg != '0) && (wb_wreg == rreg2)) ? wb_wdata : rdata2;
`else
    // Regfile is write-before-read, so its read data is already current
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_wreg, wb_wdata};
    assign rs_val    = rdata1;
    assign rt_val    = rdata2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs_val   <= '0;
            ex_rt_val   <= '0;
            ex_imm      <= '0;
            ex_dest     <= '0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_ready) begin
            if (hz) begin
                // Bubble; the stalled instruction stays in IF/ID and retries next cycle
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= if_valid;
                ex_pc       <= if_pc;
                ex_rs_val   <= rs_val;
                ex_rt_val   <= rt_val;
                ex_imm      <= sign_ext16(if_instr[15:0]);
                ex_dest     <= if_valid ? dec_dest : '0;
                ex_opcode   <= opcode;
                ex_funct    <= funct;
                ex_memread  <= if_valid && dec_memread;
                ex_regwrite <= if_valid && dec_regwrite;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - table-driven self-checking bench for decode_stage

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ex_ready;
    logic        flush;
    logic [4:0]  rreg1;
    logic [4:0]  rreg2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        wb_regwrite;
    logic [4:0]  wb_wreg;
    logic [31:0] wb_wdata;
    logic        id_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs_val;
    logic [31:0] ex_rt_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic        ex_memread;
    logic        ex_regwrite;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .ex_ready    (ex_ready),
        .flush       (flush),
        .rreg1       (rreg1),
        .rreg2       (rreg2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .wb_regwrite (wb_regwrite),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .id_stall    (id_stall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs_val   (ex_rs_val),
        .ex_rt_val   (ex_rt_val),
        .ex_imm      (ex_imm),
        .ex_dest     (ex_dest),
        .ex_opcode   (ex_opcode),
        .ex_funct    (ex_funct),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite)
    );

    // mode 0: check ex_valid only; 1: valid/regwrite/memread; 2: every ID/EX field
    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rdy;
        logic        fl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        wbw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        stall;
        int          mode;
        logic        ev;
        logic [31:0] xinstr;
        logic [31:0] xpc;
        logic [4:0]  dest;
        logic [31:0] imm;
        logic        rw;
        logic        mr;
        logic [31:0] rs;
        logic [31:0] rt;
    } vec_t;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] EXP_BYP_RS = 32'h0000_000E;
    localparam logic [31:0] EXP_BYP_RT = 32'h0000_004D;
`else
    localparam logic [31:0] EXP_BYP_RS = 32'h0000_0000;
    localparam logic [31:0] EXP_BYP_RT = 32'h0000_0005;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_valid    = 1'b0;
        if_instr    = 32'h0;
        if_pc       = 32'h0;
        ex_ready    = 1'b1;
        flush       = 1'b0;
        rdata1      = 32'h0;
        rdata2      = 32'h0;
        wb_regwrite = 1'b0;
        wb_wreg     = 5'd0;
        wb_wdata    = 32'h0;
    endtask

    initial begin
        //                v     instr         pc          rdy   fl    rd1           rd2           wbw   wbr    wbd           stall mode ev    xinstr        xpc         dest   imm           rw    mr    rs            rt
        tbl.push_back(vec_t'{1'b1, 32'h2001000E, 32'h100, 1'b1, 1'b0, 32'h0,   32'h55, 1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h2001000E, 32'h100, 5'd1,  32'hE,        1'b1, 1'b0, 32'h0,   32'h55});
        tbl.push_back(vec_t'{1'b1, 32'h8C220000, 32'h104, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C220000, 32'h104, 5'd2,  32'h0,        1'b1, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h00421820, 32'h108, 1'b1, 1'b0, 32'h7,   32'h7,  1'b0, 5'd0, 32'h0,  1'b1, 1, 1'b0, 32'h0,        32'h0,   5'd0,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h00421820, 32'h108, 1'b1, 1'b0, 32'h14,  32'h14, 1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h00421820, 32'h108, 5'd3,  32'h1820,     1'b1, 1'b0, 32'h14,  32'h14});
        for (int k = 0; k < 3; k++)
            tbl.push_back(vec_t'{1'b1, 32'hAC230004, 32'h10C, 1'b0, 1'b0, 32'hE, 32'h28, 1'b0, 5'd0, 32'h0, 1'b1, 2, 1'b1, 32'h00421820, 32'h108, 5'd3, 32'h1820, 1'b1, 1'b0, 32'h14, 32'h14});
        tbl.push_back(vec_t'{1'b1, 32'hAC230004, 32'h10C, 1'b1, 1'b0, 32'hE,   32'h28, 1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'hAC230004, 32'h10C, 5'd0,  32'h4,        1'b0, 1'b0, 32'hE,   32'h28});
        tbl.push_back(vec_t'{1'b1, 32'h8C220000, 32'h110, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C220000, 32'h110, 5'd2,  32'h0,        1'b1, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h00421820, 32'h114, 1'b1, 1'b1, 32'h7,   32'h7,  1'b0, 5'd0, 32'h0,  1'b0, 0, 1'b0, 32'h0,        32'h0,   5'd0,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h00210020, 32'h118, 1'b1, 1'b0, 32'hE,   32'hE,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h00210020, 32'h118, 5'd0,  32'h20,       1'b0, 1'b0, 32'hE,   32'hE});
        tbl.push_back(vec_t'{1'b1, 32'h8C200000, 32'h11C, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C200000, 32'h11C, 5'd0,  32'h0,        1'b0, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h00001820, 32'h120, 1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h00001820, 32'h120, 5'd3,  32'h1820,     1'b1, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h1022FFFF, 32'h124, 1'b1, 1'b0, 32'hE,   32'h2,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h1022FFFF, 32'h124, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 32'hE,   32'h2});
        tbl.push_back(vec_t'{1'b1, 32'h0C000010, 32'h200, 1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h0C000010, 32'h200, 5'd31, 32'h10,       1'b1, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h03E00008, 32'h204, 1'b1, 1'b0, 32'h204, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h03E00008, 32'h204, 5'd0,  32'h8,        1'b0, 1'b0, 32'h204, 32'h0});
        tbl.push_back(vec_t'{1'b1, 32'hFC000000, 32'h208, 1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'hFC000000, 32'h208, 5'd0,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h8C250000, 32'h20C, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C250000, 32'h20C, 5'd5,  32'h0,        1'b1, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'hAC250000, 32'h210, 1'b1, 1'b0, 32'hE,   32'h9,  1'b0, 5'd0, 32'h0,  1'b1, 1, 1'b0, 32'h0,        32'h0,   5'd0,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'hAC250000, 32'h210, 1'b1, 1'b0, 32'hE,   32'h9,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'hAC250000, 32'h210, 5'd0,  32'h0,        1'b0, 1'b0, 32'hE,   32'h9});
        tbl.push_back(vec_t'{1'b1, 32'h8C260000, 32'h214, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C260000, 32'h214, 5'd6,  32'h0,        1'b1, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h08C60000, 32'h218, 1'b1, 1'b0, 32'h3,   32'h4,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h08C60000, 32'h218, 5'd0,  32'h0,        1'b0, 1'b0, 32'h3,   32'h4});
        tbl.push_back(vec_t'{1'b1, 32'h8C270000, 32'h21C, 1'b1, 1'b0, 32'hE,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 2, 1'b1, 32'h8C270000, 32'h21C, 5'd7,  32'h0,        1'b1, 1'b1, 32'hE,   32'h0});
        tbl.push_back(vec_t'{1'b0, 32'h00E71820, 32'h220, 1'b1, 1'b0, 32'h0,   32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 0, 1'b0, 32'h0,        32'h0,   5'd0,  32'h0,        1'b0, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h20220001, 32'h224, 1'b1, 1'b0, 32'h0,   32'h0,  1'b1, 5'd1, 32'hE,  1'b0, 2, 1'b1, 32'h20220001, 32'h224, 5'd2,  32'h1,        1'b1, 1'b0, EXP_BYP_RS, 32'h0});
        tbl.push_back(vec_t'{1'b1, 32'h20020001, 32'h228, 1'b1, 1'b0, 32'h0,   32'h0,  1'b1, 5'd0, 32'h63, 1'b0, 2, 1'b1, 32'h20020001, 32'h228, 5'd2,  32'h1,        1'b1, 1'b0, 32'h0,   32'h0});
        tbl.push_back(vec_t'{1'b1, 32'hAC230000, 32'h22C, 1'b1, 1'b0, 32'hE,   32'h5,  1'b1, 5'd3, 32'h4D, 1'b0, 2, 1'b1, 32'hAC230000, 32'h22C, 5'd0,  32'h0,        1'b0, 1'b0, 32'hE,   EXP_BYP_RT});

        // Reset held two cycles
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",    32'(ex_valid),    32'h0);
        check("rst_pc",       ex_pc,            32'h0);
        check("rst_rs",       ex_rs_val,        32'h0);
        check("rst_rt",       ex_rt_val,        32'h0);
        check("rst_imm",      ex_imm,           32'h0);
        check("rst_dest",     32'(ex_dest),     32'h0);
        check("rst_opcode",   32'(ex_opcode),   32'h0);
        check("rst_funct",    32'(ex_funct),    32'h0);
        check("rst_memread",  32'(ex_memread),  32'h0);
        check("rst_regwrite", 32'(ex_regwrite), 32'h0);
        check("rst_stall",    32'(id_stall),    32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            if_valid    = tbl[i].v;
            if_instr    = tbl[i].instr;
            if_pc       = tbl[i].pc;
            ex_ready    = tbl[i].rdy;
            flush       = tbl[i].fl;
            rdata1      = tbl[i].rd1;
            rdata2      = tbl[i].rd2;
            wb_regwrite = tbl[i].wbw;
            wb_wreg     = tbl[i].wbr;
            wb_wdata    = tbl[i].wbd;
            #1;
            check($sformatf("r%0d_stall", i), 32'(id_stall), 32'(tbl[i].stall));
            @(posedge clk);
            #1;
            check($sformatf("r%0d_valid", i), 32'(ex_valid), 32'(tbl[i].ev));
            if (tbl[i].mode >= 1) begin
                check($sformatf("r%0d_regwrite", i), 32'(ex_regwrite), 32'(tbl[i].rw));
                check($sformatf("r%0d_memread", i),  32'(ex_memread),  32'(tbl[i].mr));
            end
            if (tbl[i].mode >= 2) begin
                check($sformatf("r%0d_pc", i),     ex_pc,            tbl[i].xpc);
                check($sformatf("r%0d_dest", i),   32'(ex_dest),     32'(tbl[i].dest));
                check($sformatf("r%0d_imm", i),    ex_imm,           tbl[i].imm);
                check($sformatf("r%0d_opcode", i), 32'(ex_opcode),   32'(tbl[i].xinstr[31:26]));
                check($sformatf("r%0d_funct", i),  32'(ex_funct),    32'(tbl[i].xinstr[5:0]));
                check($sformatf("r%0d_rs", i),     ex_rs_val,        tbl[i].rs);
                check($sformatf("r%0d_rt", i),     ex_rt_val,        tbl[i].rt);
            end
        end

        // Reset arriving during a load-use stall
        @(negedge clk);
        drive_idle();
        if_valid = 1'b1;
        if_instr = 32'h8C220000;
        if_pc    = 32'h300;
        @(posedge clk);
        @(negedge clk);
        if_instr = 32'h00421820;
        if_pc    = 32'h304;
        reset    = 1'b1;
        #1;
        check("rms_stall_before", 32'(id_stall), 32'h1);
        @(posedge clk);
        #1;
        check("rms_valid",   32'(ex_valid),   32'h0);
        check("rms_memread", 32'(ex_memread), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rms_stall_after", 32'(id_stall), 32'h0);
        @(posedge clk);
        #1;
        check("rms_add_valid", 32'(ex_valid), 32'h1);
        check("rms_add_dest",  32'(ex_dest),  32'h3);
        check("rms_add_pc",    ex_pc,         32'h304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
